// File: rtl/ps2_frame_receiver.sv
// PS/2 keyboard receiver: pin synchronisation, clock glitch filter, 11-bit frame deframing, E0/F0 scan-code decode.
// Optional PS2_PARITY_CHECK_EN: when defined, frames with bad odd parity or a low stop bit are rejected with rx_err.
module ps2_frame_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK_50M,
    input  logic       RSTn,
    input  logic       ps2k_clk,
    input  logic       ps2k_data,
    output logic [7:0] ps2_byte,
    output logic       ps2_ext,
    output logic       ps2_state,
    output logic       key_pulse,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync, data_sync;
    logic          clk_s, data_s;
    logic          filt_clk;
    logic [FW-1:0] filt_cnt;
    logic          fe;
    state_t        state_q, state_d;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic          timeout, frame_done, frame_good;
    logic          ext_pend, brk_pend;

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            clk_sync  <= {clk_sync[0], ps2k_clk};
            data_sync <= {data_sync[0], ps2k_data};
        end
    end

    assign clk_s  = clk_sync[1];
    assign data_s = data_sync[1];

    // The filtered clock flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == filt_clk) begin
            filt_cnt <= '0;
        end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_clk <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FW'(1);
        end
    end

    assign fe         = filt_clk && !clk_s && (filt_cnt == FW'(FILTER_LEN - 1));
    assign timeout    = (state_q != IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES - 1)) && !fe;
    assign frame_done = fe && (state_q == STOP);

`ifdef PS2_PARITY_CHECK_EN
    logic parity_q;
    assign frame_good = data_s && (^{shift_q, parity_q});
`else
    assign frame_good = 1'b1;
`endif

    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (fe) begin
            unique case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_cnt == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end else if (timeout) begin
            state_d = IDLE;
        end
    end

    // Shift register, bit counter and inactivity timer; an fe always takes priority over a timeout.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            shift_q <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
`ifdef PS2_PARITY_CHECK_EN
            parity_q <= 1'b0;
`endif
        end else if (fe) begin
            to_cnt <= '0;
            case (state_q)
                IDLE: bit_cnt <= '0;
                DATA: begin
                    shift_q <= {data_s, shift_q[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
`ifdef PS2_PARITY_CHECK_EN
                PARITY: parity_q <= data_s;
`endif
                default: ;
            endcase
        end else if (timeout) begin
            shift_q <= '0;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else if (state_q == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TW'(1);
        end
    end

    // Scan-code decode: E0/F0 only arm pending flags; the next plain byte is a make or a break.
    always_ff @(posedge CLK_50M or negedge RSTn) begin
        if (!RSTn) begin
            ps2_byte  <= 8'h00;
            ps2_ext   <= 1'b0;
            ps2_state <= 1'b0;
            key_pulse <= 1'b0;
            rx_err    <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else begin
            key_pulse <= 1'b0;
            rx_err    <= timeout || (frame_done && !frame_good);
            if (frame_done && frame_good) begin
                if (shift_q == 8'hE0) begin
                    ext_pend <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_pend <= 1'b1;
                end else if (brk_pend) begin
                    if (shift_q == ps2_byte && ext_pend == ps2_ext) ps2_state <= 1'b0;
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end else begin
                    key_pulse <= !ps2_state || ({ext_pend, shift_q} != {ps2_ext, ps2_byte});
                    ps2_byte  <= shift_q;
                    ps2_ext   <= ext_pend;
                    ps2_state <= 1'b1;
                    ext_pend  <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Bench for ps2_frame_receiver: directed scan-code sequences plus random frames against a behavioural key model.
module tb_ps2_frame_receiver;

    localparam int HALF = 25;
    localparam int TO   = 600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       kclk = 1'b1;
    logic       kdata = 1'b1;
    logic [7:0] ps2_byte;
    logic       ps2_ext, ps2_state, key_pulse, rx_err;

    int n_vec = 0;
    int n_err = 0;
    int pulse_cnt = 0;
    int err_cnt = 0;

    logic [8:0] exp_q[$];

    logic [7:0] m_byte = 8'h00;
    logic       m_ext = 1'b0, m_state = 1'b0, m_extp = 1'b0, m_brkp = 1'b0;
    int         e_pulse, e_err;

    ps2_frame_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TO)) dut (
        .CLK_50M(clk), .RSTn(rst_n), .ps2k_clk(kclk), .ps2k_data(kdata),
        .ps2_byte(ps2_byte), .ps2_ext(ps2_ext), .ps2_state(ps2_state),
        .key_pulse(key_pulse), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_err) err_cnt++;
            if (key_pulse) begin
                pulse_cnt++;
                if (exp_q.size() == 0) check("unexpected_pulse", {23'd0, ps2_ext, ps2_byte}, 32'h1ff);
                else check("pulse_key", {23'd0, ps2_ext, ps2_byte}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    // Key-level reference: what a keyboard controller should see for each received byte.
    task automatic model_apply(input logic [7:0] b, input bit good);
        e_pulse = 0;
        e_err   = 0;
        if (!good) e_err = 1;
        else if (b == 8'hE0) m_extp = 1'b1;
        else if (b == 8'hF0) m_brkp = 1'b1;
        else if (m_brkp) begin
            if (b == m_byte && m_extp == m_ext) m_state = 1'b0;
            m_extp = 1'b0;
            m_brkp = 1'b0;
        end else begin
            e_pulse = (!m_state || {m_extp, b} != {m_ext, m_byte}) ? 1 : 0;
            m_byte  = b;
            m_ext   = m_extp;
            m_state = 1'b1;
            m_extp  = 1'b0;
            if (e_pulse != 0) exp_q.push_back({m_ext, m_byte});
        end
    endtask

    task automatic send_bit(input bit b, input bit glitch);
        kdata = b;
        if (glitch) begin
            wait_cyc(8);
            kclk = 1'b0;
            wait_cyc(3);
            kclk = 1'b1;
            wait_cyc(HALF - 11);
        end else begin
            wait_cyc(HALF);
        end
        kclk = 1'b0;
        wait_cyc(HALF);
        kclk = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        #1;
        check({tag, "_byte"},  {24'd0, ps2_byte}, {24'd0, m_byte});
        check({tag, "_ext"},   {31'd0, ps2_ext},  {31'd0, m_ext});
        check({tag, "_state"}, {31'd0, ps2_state}, {31'd0, m_state});
        check({tag, "_pulses"}, pulse_cnt, e_pulse);
        check({tag, "_errs"},   err_cnt, e_err);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit glitch);
        logic par;
        bit   good;
`ifdef PS2_PARITY_CHECK_EN
        good = !bad_par;
`else
        good = 1'b1;
`endif
        par = bad_par ? ^b : ~^b;
        pulse_cnt = 0;
        err_cnt   = 0;
        model_apply(b, good);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(par, glitch);
        send_bit(1'b1, glitch);
        wait_cyc(20);
        check_outputs(tag);
    endtask

    initial begin
        logic [7:0] rb;
        wait_cyc(5);
        #1;
        check("rst_byte",  {24'd0, ps2_byte}, 32'h0);
        check("rst_ext",   {31'd0, ps2_ext}, 32'h0);
        check("rst_state", {31'd0, ps2_state}, 32'h0);
        check("rst_pulse", {31'd0, key_pulse}, 32'h0);
        check("rst_err",   {31'd0, rx_err}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(20);

        send_frame("make_1c", 8'h1C, 1'b0, 1'b0);
        send_frame("brk_f0", 8'hF0, 1'b0, 1'b0);
        send_frame("brk_1c", 8'h1C, 1'b0, 1'b0);
        send_frame("ext_e0", 8'hE0, 1'b0, 1'b0);
        send_frame("ext_6b", 8'h6B, 1'b0, 1'b0);
        send_frame("ebrk_e0", 8'hE0, 1'b0, 1'b0);
        send_frame("ebrk_f0", 8'hF0, 1'b0, 1'b0);
        send_frame("ebrk_6b", 8'h6B, 1'b0, 1'b0);
        send_frame("badpar_1c", 8'h1C, 1'b1, 1'b0);

        // Abandoned frame: start plus four data bits, then the clock idles past the timeout.
        pulse_cnt = 0;
        err_cnt   = 0;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        wait_cyc(TO + 50);
        e_pulse = 0;
        e_err   = 1;
        check_outputs("timeout");
        send_frame("after_to_29", 8'h29, 1'b0, 1'b0);

        send_frame("typ1_1c", 8'h1C, 1'b0, 1'b0);
        send_frame("typ2_1c", 8'h1C, 1'b0, 1'b0);
        send_frame("glitch_33", 8'h33, 1'b0, 1'b1);

        // Reset in the middle of a frame.
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        rst_n = 1'b0;
        wait_cyc(3);
        #1;
        check("midrst_byte",  {24'd0, ps2_byte}, 32'h0);
        check("midrst_ext",   {31'd0, ps2_ext}, 32'h0);
        check("midrst_state", {31'd0, ps2_state}, 32'h0);
        m_byte = 8'h00; m_ext = 1'b0; m_state = 1'b0; m_extp = 1'b0; m_brkp = 1'b0;
        rst_n = 1'b1;
        wait_cyc(10);
        send_frame("after_rst_75", 8'h75, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0:       send_frame("rnd_e0", 8'hE0, 1'b0, 1'b0);
                1:       send_frame("rnd_f0", 8'hF0, 1'b0, 1'b0);
                2:       send_frame("rnd_held", m_byte, 1'b0, 1'b0);
                3: begin
                    rb = 8'($urandom_range(0, 255));
                    send_frame("rnd_badpar", rb, 1'b1, 1'b0);
                end
                default: begin
                    rb = 8'($urandom_range(0, 255));
                    send_frame("rnd_byte", rb, 1'b0, 1'b0);
                end
            endcase
        end

        check("exp_q_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
Front end of the keyboard input path. Takes the raw PS/2 clock/data pins, filters and synchronises them, and deframes 11-bit PS/2 frames. It then decodes the scan-code protocol (E0 extended prefix, F0 break prefix) into ps2_byte / ps2_state for the keyboard controllers. Sits between the board pins and Keyboard_Ctrl / Keyboard, replacing the old PS/2 receiver top.

Parameters:
FILTER_LEN, 8, consecutive CLK_50M samples a synchronised ps2k_clk level must hold before it is accepted (glitch filter).
TIMEOUT_CYCLES, 50000, CLK_50M cycles without an accepted falling edge before a partial frame is abandoned (1 ms).

Ports:
CLK_50M  in  1  system clock, 50 MHz
RSTn  in  1  asynchronous active-low reset
ps2k_clk  in  1  raw PS/2 clock pin, asynchronous
ps2k_data  in  1  raw PS/2 data pin, asynchronous
ps2_byte  out  8  scan code of the last make event (extended prefix stripped)
ps2_ext  out  1  1 when ps2_byte came with an E0 prefix
ps2_state  out  1  level: 1 while the key in ps2_byte is held, 0 after its break
key_pulse  out  1  one-cycle strobe on a new key press
rx_err  out  1  one-cycle strobe on frame error or timeout

Behaviour:
- Single clock CLK_50M; reset asynchronous, active-low (RSTn). All flops clear asynchronously.
- Reset values: ps2_byte=0x00, ps2_ext=0, ps2_state=0, key_pulse=0, rx_err=0. FSM=IDLE; shift register, bit counter, timeout counter, pending flags cleared; filtered clock=1.
- Input conditioning:
  - Both pins pass through a 2-FF synchroniser.
  - Filtered clock changes only after FILTER_LEN identical consecutive synchronised samples.
  - An accepted falling edge (fe) is a one-cycle flag: filtered clock 1→0.
  - Data is sampled from the synchronised ps2k_data in the fe cycle.
- Frame FSM:
  - IDLE: on fe with data=0, go to DATA with bit_cnt=0. On fe with data=1, stay in IDLE and discard.
  - DATA: on each fe, shift data in LSB first. After the 8th bit (bit_cnt=7), go to PARITY.
  - PARITY: on fe, capture the parity bit and go to STOP.
  - STOP: on fe, capture the stop bit and return to IDLE.
  - Frame good = stop bit is 1 AND the XOR of 8 data bits and parity bit is 1 (odd parity).
  - Good frame: the byte goes to the decode layer in the same cycle.
  - Bad frame: rx_err pulses for 1 cycle, and no decode happens.
- Timeout:
  - The counter clears on every fe and also while in IDLE.
  - In a non-IDLE state, reaching TIMEOUT_CYCLES-1 forces IDLE, pulses rx_err, and clears the shift register and bit_cnt. Pending flags are kept.
- Decode layer (updates on a good frame; outputs registered, visible the cycle after the stop-bit fe):
  - Byte E0: set ext_pending. No output change.
  - Byte F0: set brk_pending. No output change.
  - Other byte with brk_pending=1: if byte==ps2_byte and ext_pending==ps2_ext, then ps2_state←0. In all cases clear both pending flags. ps2_byte is unchanged and key_pulse stays 0.
  - Other byte with brk_pending=0 (make): ps2_byte←byte, ps2_ext←ext_pending, ps2_state←1, clear ext_pending.
  - key_pulse=1 for one cycle only if ps2_state was 0, or {ext,byte} differs from the held value. A typematic repeat of the held key produces no pulse.
- Simultaneous events: a timeout and an fe in the same cycle → the fe wins (counter clears, FSM advances).
- RSTn asserted mid-frame: immediate return to reset state. The partial frame is lost; the next start bit is received normally.

Optional Feature:
PS2_PARITY_CHECK_EN
- Defined: the frame-good rule is as above; bad parity or stop bit → rx_err and the frame is discarded.
- Undefined: parity and stop bits are clocked through but ignored. Every complete frame is decoded. rx_err pulses only on timeout.

Test Plan:
- Reset, then a good frame 0x1C (parity 0, stop 1) → ps2_byte=0x1C, ps2_ext=0, ps2_state=1, key_pulse high exactly 1 cycle after the stop fe; rx_err=0.
- After the above, frames F0, 1C → ps2_state=0, ps2_byte stays 0x1C, no key_pulse.
- Frames E0, 6B, then E0, F0, 6B → ps2_byte=0x6B, ps2_ext=1, ps2_state=1, one key_pulse; after the break, ps2_state=0.
- With PS2_PARITY_CHECK_EN: frame 0x1C with parity bit 1 → rx_err 1-cycle pulse, outputs unchanged. Without the macro → decoded as a make of 0x1C.
- Start bit plus 4 data bits, then ps2k_clk held high for TIMEOUT_CYCLES → rx_err pulse, FSM back in IDLE. A following good frame 0x29 → ps2_byte=0x29, key_pulse.
- Make 0x1C twice (typematic) → single key_pulse, ps2_state stays 1. Also: a 3-cycle low glitch on ps2k_clk with FILTER_LEN=8 → no bit sampled. RSTn pulsed after 5 bits → all outputs 0; the next full frame 0x75 decodes.
